// File: rtl/windower_pkg.sv
// Shared types and helpers for the 1-D sliding-window generator.
package windower_pkg;

    typedef enum logic {MODE_PAIR, MODE_PAD3} mode_e;

    function automatic int img_size(input int log2_size);
        return 1 << log2_size;
    endfunction

endpackage

// File: rtl/window_shift_reg.sv
// History of the most recent accepted samples; tap[0] is the newest.
module window_shift_reg #(
    parameter int DEPTH = 1,
    parameter int W     = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         shift,
    input  logic [W-1:0] din,
    output logic [W-1:0] tap [DEPTH-1:0]
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) tap[i] <= '0;
        end else if (shift) begin
            tap[0] <= din;
            for (int i = 1; i < DEPTH; i++) tap[i] <= tap[i-1];
        end
    end

endmodule

// File: rtl/windower.sv
// Sliding-window generator: pairs (WS=2,S=2) or zero-padded triples (WS=3,S=1,P=1).
module windower
    import windower_pkg::*;
#(
    parameter int WINDOW_SIZE   = 2,
    parameter int NO_CH         = 10,
    parameter int LOG2_IMG_SIZE = 10,
    parameter int STRIDE        = 2,
    parameter int ZERO_PADDING  = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             vld_in,
    input  logic [NO_CH-1:0] data_in,
    output logic             vld_out,
    output logic [NO_CH-1:0] data_out [WINDOW_SIZE-1:0]
);

    localparam int    IMG_SIZE = img_size(LOG2_IMG_SIZE);
    localparam mode_e MODE     = (WINDOW_SIZE == 3) ? MODE_PAD3 : MODE_PAIR;
    localparam int    TAPS     = WINDOW_SIZE - 1;
    localparam logic [LOG2_IMG_SIZE-1:0] LAST_POS = LOG2_IMG_SIZE'(IMG_SIZE - 1);

    if (!((WINDOW_SIZE == 3 && STRIDE == 1 && ZERO_PADDING == 1) ||
          (WINDOW_SIZE == 2 && STRIDE == 2 && ZERO_PADDING == 0))) begin : g_bad_cfg
        $error("windower: unsupported WINDOW_SIZE/STRIDE/ZERO_PADDING combination");
    end

    logic [LOG2_IMG_SIZE-1:0] pos;
    logic                     last;
    logic [NO_CH-1:0]         tap     [TAPS-1:0];
    logic                     fire;
    logic [NO_CH-1:0]         win_nxt [WINDOW_SIZE-1:0];

    assign last = (pos == LAST_POS);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        pos <= '0;
        else if (vld_in) pos <= last ? '0 : pos + LOG2_IMG_SIZE'(1);
    end

    window_shift_reg #(.DEPTH(TAPS), .W(NO_CH)) u_taps (
        .clk   (clk),
        .rst   (rst),
        .shift (vld_in),
        .din   (data_in),
        .tap   (tap)
    );

    if (MODE == MODE_PAD3) begin : g_pad3
        // Right-edge window is emitted one cycle late, after the image's last sample is in the taps.
        logic pend;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) pend <= 1'b0;
            else      pend <= vld_in && last;
        end

        always_comb begin
            fire = 1'b0;
            for (int i = 0; i < WINDOW_SIZE; i++) win_nxt[i] = '0;
            if (pend) begin
                fire       = 1'b1;
                win_nxt[1] = tap[0];
                win_nxt[2] = tap[1];
            end else if (vld_in && pos != '0) begin
                // pos==1: the oldest tap belongs to the previous image, so pad it
                fire       = 1'b1;
                win_nxt[0] = data_in;
                win_nxt[1] = tap[0];
                win_nxt[2] = (pos == LOG2_IMG_SIZE'(1)) ? '0 : tap[1];
            end
        end
    end else begin : g_pair
        always_comb begin
            fire       = vld_in && pos[0];
            win_nxt[0] = data_in;
            win_nxt[1] = tap[0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_out <= 1'b0;
            for (int i = 0; i < WINDOW_SIZE; i++) data_out[i] <= '0;
        end else begin
            vld_out <= fire;
            if (fire) begin
                for (int i = 0; i < WINDOW_SIZE; i++) data_out[i] <= win_nxt[i];
            end
        end
    end

endmodule

// File: tb/tb_windower.sv
// Scoreboard bench driving both supported windower configurations with the same counting stream.
module tb_windower;

    localparam int NC = 10;
    localparam int LG = 10;
    localparam int N  = 1 << LG;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          vld_in = 1'b0;
    logic [NC-1:0] data_in = '0;
    logic          a_vld, b_vld;
    logic [NC-1:0] a_out [1:0];
    logic [NC-1:0] b_out [2:0];

    windower #(.WINDOW_SIZE(2), .NO_CH(NC), .LOG2_IMG_SIZE(LG), .STRIDE(2), .ZERO_PADDING(0)) u_pair (
        .clk(clk), .rst(rst), .vld_in(vld_in), .data_in(data_in), .vld_out(a_vld), .data_out(a_out));

    windower #(.WINDOW_SIZE(3), .NO_CH(NC), .LOG2_IMG_SIZE(LG), .STRIDE(1), .ZERO_PADDING(1)) u_pad3 (
        .clk(clk), .rst(rst), .vld_in(vld_in), .data_in(data_in), .vld_out(b_vld), .data_out(b_out));

    always #5 clk = ~clk;

    int          n_chk = 0, n_fail = 0, a_pulses = 0, b_pulses = 0;
    logic [29:0] qa[$], qb[$];
    logic [29:0] last_a = '0, last_b = '0;
    int          mp = 0;
    logic [NC-1:0] h1 = '0, h2 = '0, dcnt = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Windows packed as {[2],[1],[0]}; expected values built from the model history.
    task automatic send(input bit v);
        logic [NC-1:0] old;
        vld_in  = v;
        data_in = v ? dcnt : NC'($urandom);
        if (v) begin
            old = (mp == 1) ? '0 : h2;
            if (mp[0])      qa.push_back({10'b0, h1, dcnt});
            if (mp >= 1)    qb.push_back({old, h1, dcnt});
            if (mp == N-1)  qb.push_back({h1, dcnt, 10'b0});
            h2   = h1;
            h1   = dcnt;
            dcnt = dcnt + 1'b1;
            mp   = (mp + 1) % N;
        end
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        logic [29:0] ga, gb, e;
        ga = {10'b0, a_out[1], a_out[0]};
        gb = {b_out[2], b_out[1], b_out[0]};
        if (a_vld) begin
            a_pulses++;
            chk("a_expected_pulse", 32'(qa.size() != 0), 1);
            if (qa.size() != 0) begin
                e = qa.pop_front();
                chk("a_window", 32'(ga), 32'(e));
                last_a = e;
            end
        end else chk("a_hold", 32'(ga), 32'(last_a));
        if (b_vld) begin
            b_pulses++;
            chk("b_expected_pulse", 32'(qb.size() != 0), 1);
            if (qb.size() != 0) begin
                e = qb.pop_front();
                chk("b_window", 32'(gb), 32'(e));
                last_b = e;
            end
        end else chk("b_hold", 32'(gb), 32'(last_b));
    end

    initial begin
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_a_vld", 32'(a_vld), 0);
        chk("rst_b_vld", 32'(b_vld), 0);
        chk("rst_a_data", 32'({a_out[1], a_out[0]}), 0);
        chk("rst_b_data", 32'({b_out[2], b_out[1], b_out[0]}), 0);
        rst = 1'b1;

        // two images back to back, then two images with one idle cycle after each
        repeat (2*N) send(1'b1);
        repeat (2) begin
            repeat (N) send(1'b1);
            send(1'b0);
        end
        // one image with random gaps
        for (int i = 0; i < N; i++) begin
            repeat ($urandom_range(0, 2)) send(1'b0);
            send(1'b1);
        end
        send(1'b0);
        send(1'b0);

        // reset right after the p=499 windows are produced
        repeat (500) send(1'b1);
        vld_in = 1'b0;
        @(negedge clk);
        #1;
        rst = 1'b0;
        last_a = '0;
        last_b = '0;
        #1;
        chk("midrst_a_vld", 32'(a_vld), 0);
        chk("midrst_b_vld", 32'(b_vld), 0);
        chk("midrst_a_data", 32'({a_out[1], a_out[0]}), 0);
        chk("midrst_b_data", 32'({b_out[2], b_out[1], b_out[0]}), 0);
        chk("midrst_qa", qa.size(), 0);
        chk("midrst_qb", qb.size(), 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        mp = 0;
        h1 = '0;
        h2 = '0;
        repeat (N) send(1'b1);
        send(1'b0);
        send(1'b0);

        chk("a_queue_empty", qa.size(), 0);
        chk("b_queue_empty", qb.size(), 0);
        chk("a_pulse_total", a_pulses, 6*512 + 250);
        chk("b_pulse_total", b_pulses, 6*1024 + 499);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
